mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 512x8 RAM: one load/store at a time, alignment
// checking, stale-complete masking, timeout, and zero/sign-extended load data.
module mem_access_ctrl #(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        rw,
    input  logic [8:0]  addr,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        memFuncActive,
    output logic        readWrite,
    output logic [8:0]  address,
    output logic [31:0] memDataOut,
    output logic [1:0]  dataSize,
    input  logic        memFuncComplete,
    input  logic [31:0] memDataIn
);
    // state | meaning
    // IDLE  | RAM idle, req sampled and alignment checked
    // WAIT  | memFuncActive high, counting edges until complete or timeout
    // DONE  | one-cycle memFuncActive low gap, done/err visible

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateType;

    stateType      state;
    logic [CW-1:0] waitCnt;
    logic [CW-1:0] waitNext;
    logic          signedFlag;
    logic          misaligned;
    logic          accept;
    logic [31:0]   loadData;

    // waitNext is k, the index of the WAIT edge currently being evaluated
    assign waitNext = waitCnt + CW'(1);
    assign accept   = memFuncComplete && (waitNext >= CW'(MIN_WAIT));

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b11:   misaligned = (addr[1:0] != 2'b00);
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        loadData = '0;
        case (dataSize)
            2'b11:   loadData = memDataIn;
            2'b01:   loadData = {{16{signedFlag & memDataIn[15]}}, memDataIn[15:0]};
            default: loadData = {{24{signedFlag & memDataIn[7]}}, memDataIn[7:0]};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            waitCnt       <= '0;
            signedFlag    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
            memFuncActive <= 1'b0;
            readWrite     <= 1'b0;
            address       <= '0;
            memDataOut    <= '0;
            dataSize      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done          <= 1'b0;
                    err           <= 1'b0;
                    busy          <= 1'b0;
                    memFuncActive <= 1'b0;
                    if (req) begin
                        if (misaligned) begin
                            err <= 1'b1;
                        end else begin
                            readWrite     <= rw;
                            address       <= addr;
                            dataSize      <= size;
                            memDataOut    <= wdata;
                            signedFlag    <= signedLoad;
                            memFuncActive <= 1'b1;
                            busy          <= 1'b1;
                            waitCnt       <= '0;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    waitCnt <= waitNext;
                    // complete takes priority over a timeout landing on the same edge
                    if (accept) begin
                        if (!readWrite) rdata <= loadData;
                        memFuncActive <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (waitNext == CW'(TIMEOUT)) begin
                        memFuncActive <= 1'b0;
                        done          <= 1'b1;
                        err           <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: big-endian RAM model with programmable completion latency,
// plus a byte-array reference of memory contents and expected load results.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req, req3;
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        memFuncActive, readWrite;
    logic [8:0]  address;
    logic [31:0] memDataOut;
    logic [1:0]  dataSize;
    logic        memFuncComplete = 1'b0;
    logic [31:0] memDataIn = '0;

    logic        busy3, done3, err3, act3, rw3;
    logic [31:0] rdata3, mdo3;
    logic [8:0]  addr3;
    logic [1:0]  ds3;

    logic [7:0]  ramMem [0:511];
    logic [7:0]  refMem [0:511];
    logic [31:0] expRdata;
    int          ramLat;
    int          nCompared   = 0;
    int          nMismatched = 0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.MIN_WAIT(1), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .rw(rw), .addr(addr), .size(size),
        .signedLoad(signedLoad), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .memFuncActive(memFuncActive), .readWrite(readWrite),
        .address(address), .memDataOut(memDataOut), .dataSize(dataSize),
        .memFuncComplete(memFuncComplete), .memDataIn(memDataIn)
    );

    // second instance with a RAM that leaves complete stuck high
    mem_access_ctrl #(.MIN_WAIT(3), .TIMEOUT(TIMEOUT)) dut3 (
        .Clk(Clk), .Reset(Reset), .req(req3), .rw(rw), .addr(addr), .size(size),
        .signedLoad(signedLoad), .wdata(wdata), .busy(busy3), .done(done3), .err(err3),
        .rdata(rdata3), .memFuncActive(act3), .readWrite(rw3),
        .address(addr3), .memDataOut(mdo3), .dataSize(ds3),
        .memFuncComplete(1'b1), .memDataIn(32'hCAFE0123)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int numBytes(input logic [1:0] sz);
        return (sz == 2'b11) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] refLoad(input logic [8:0] a, input logic [1:0] sz, input bit sgn);
        int     nb;
        longint v;
        nb = numBytes(sz);
        v  = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + longint'(refMem[int'(a) + i]);
        if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic void refStore(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int nb;
        nb = numBytes(sz);
        for (int i = 0; i < nb; i++) refMem[int'(a) + i] = 8'(wd >> (8 * (nb - 1 - i)));
    endfunction

    // RAM: raises complete on the ramLat-th cycle of memFuncActive (0 = never)
    int          activeCnt = 0;
    bit          served = 1'b0;
    always @(negedge Clk) begin
        int          nb;
        logic [31:0] rd;
        if (!memFuncActive) begin
            activeCnt       = 0;
            served          = 1'b0;
            memFuncComplete = 1'b0;
        end else begin
            activeCnt++;
            if (!served && ramLat != 0 && activeCnt >= ramLat) begin
                served          = 1'b1;
                memFuncComplete = 1'b1;
                nb              = numBytes(dataSize);
                if (readWrite) begin
                    for (int i = 0; i < nb; i++)
                        ramMem[int'(address) + i] = 8'(memDataOut >> (8 * (nb - 1 - i)));
                end else begin
                    rd = '0;
                    for (int i = 0; i < nb; i++) rd = (rd << 8) | 32'(ramMem[int'(address) + i]);
                    if (nb < 4) rd = rd | ($urandom << (8 * nb));
                    memDataIn = rd;
                end
            end
        end
    end

    task automatic access(input bit rwI, input logic [8:0] a, input logic [1:0] sz,
                          input bit sgn, input logic [31:0] wd, input int lat);
        bit mis, expErr;
        int expK, n;
        mis    = (sz == 2'b10) || (sz == 2'b11 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
        ramLat = lat;
        req = 1'b1; rw = rwI; addr = a; size = sz; signedLoad = sgn; wdata = wd;
        @(negedge Clk);
        req = 1'b0; rw = 1'($urandom); addr = 9'($urandom); size = 2'($urandom);
        signedLoad = 1'($urandom); wdata = $urandom;
        if (mis) begin
            checkVal("mis_err",   32'(err), 32'd1);
            checkVal("mis_done",  32'(done), 32'd0);
            checkVal("mis_act",   32'(memFuncActive), 32'd0);
            checkVal("mis_busy",  32'(busy), 32'd0);
            checkVal("mis_rdata", rdata, expRdata);
            @(negedge Clk);
            checkVal("mis_err_clr", 32'(err), 32'd0);
            checkVal("mis_act2",    32'(memFuncActive), 32'd0);
        end else begin
            expErr = (lat == 0 || lat > TIMEOUT);
            expK   = expErr ? TIMEOUT : lat;
            checkVal("wait_act",  32'(memFuncActive), 32'd1);
            checkVal("wait_busy", 32'(busy), 32'd1);
            checkVal("wait_addr", 32'(address), 32'(a));
            checkVal("wait_rw",   32'(readWrite), 32'(rwI));
            checkVal("wait_size", 32'(dataSize), 32'(sz));
            checkVal("wait_wd",   memDataOut, wd);
            n = 0;
            while (!done && n < 40) begin
                @(negedge Clk);
                n++;
            end
            checkVal("latency",  32'(n), 32'(expK));
            checkVal("acc_err",  32'(err), 32'(expErr));
            checkVal("acc_act",  32'(memFuncActive), 32'd0);
            checkVal("acc_busy", 32'(busy), 32'd1);
            if (!expErr) begin
                if (rwI) refStore(a, sz, wd);
                else     expRdata = refLoad(a, sz, sgn);
            end
            checkVal("rdata", rdata, expRdata);
            @(negedge Clk);
            checkVal("idle_done", 32'(done), 32'd0);
            checkVal("idle_err",  32'(err), 32'd0);
            checkVal("idle_busy", 32'(busy), 32'd0);
            checkVal("idle_act",  32'(memFuncActive), 32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n, diffs, latR;
        bit          rwR, sgnR;
        logic [1:0]  szR;
        logic [8:0]  aR;
        Reset = 1'b1; req = 1'b0; req3 = 1'b0; rw = 1'b0; addr = '0; size = '0;
        signedLoad = 1'b0; wdata = '0; ramLat = 1; expRdata = '0;
        for (int i = 0; i < 512; i++) begin
            ramMem[i] = 8'($urandom);
            refMem[i] = ramMem[i];
        end
        ramMem[48] = 8'h80; refMem[48] = 8'h80;
        ramMem[49] = 8'hFF; refMem[49] = 8'hFF;
        repeat (3) @(negedge Clk);
        checkVal("rst_act",   32'(memFuncActive), 32'd0);
        checkVal("rst_busy",  32'(busy), 32'd0);
        checkVal("rst_done",  32'(done), 32'd0);
        checkVal("rst_err",   32'(err), 32'd0);
        checkVal("rst_rdata", rdata, 32'd0);
        checkVal("rst_addr",  32'(address), 32'd0);
        checkVal("rst_size",  32'(dataSize), 32'd0);
        checkVal("rst_wd",    memDataOut, 32'd0);
        checkVal("rst_rw",    32'(readWrite), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        access(1'b1, 9'h028, 2'b11, 1'b0, 32'hDEADBEEF, 1);
        checkVal("ram_bytes", {ramMem[40], ramMem[41], ramMem[42], ramMem[43]}, 32'hDEADBEEF);
        access(1'b0, 9'h028, 2'b11, 1'b0, 32'h0, 1);
        checkVal("ld_word", rdata, 32'hDEADBEEF);

        access(1'b0, 9'h030, 2'b01, 1'b1, 32'h0, 2);
        checkVal("ld_half_s", rdata, 32'hFFFF80FF);
        access(1'b0, 9'h030, 2'b01, 1'b0, 32'h0, 1);
        checkVal("ld_half_u", rdata, 32'h000080FF);
        access(1'b0, 9'h031, 2'b00, 1'b1, 32'h0, 3);
        checkVal("ld_byte_s", rdata, 32'hFFFFFFFF);

        access(1'b0, 9'h002, 2'b11, 1'b0, 32'h0, 1);
        access(1'b1, 9'h003, 2'b01, 1'b0, 32'h1234, 1);
        access(1'b0, 9'h004, 2'b10, 1'b0, 32'h0, 1);
        checkVal("mis_keep", rdata, 32'hFFFFFFFF);

        access(1'b0, 9'h028, 2'b11, 1'b0, 32'h0, 0);
        access(1'b1, 9'h100, 2'b11, 1'b0, 32'h01020304, TIMEOUT + 1);
        access(1'b0, 9'h030, 2'b01, 1'b0, 32'h0, TIMEOUT);
        checkVal("to_edge_ld", rdata, 32'h000080FF);

        ramLat = 5;
        req = 1'b1; rw = 1'b0; addr = 9'h040; size = 2'b11; signedLoad = 1'b0;
        @(negedge Clk);
        req = 1'b0;
        checkVal("rmw_act_pre", 32'(memFuncActive), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        expRdata = '0;
        checkVal("rmw_act",   32'(memFuncActive), 32'd0);
        checkVal("rmw_done",  32'(done), 32'd0);
        checkVal("rmw_err",   32'(err), 32'd0);
        checkVal("rmw_busy",  32'(busy), 32'd0);
        checkVal("rmw_rdata", rdata, 32'd0);
        checkVal("rmw_addr",  32'(address), 32'd0);
        checkVal("rmw_wd",    memDataOut, 32'd0);
        @(negedge Clk);
        checkVal("rmw_nodone", 32'(done), 32'd0);
        access(1'b0, 9'h040, 2'b11, 1'b0, 32'h0, 2);

        req3 = 1'b1; rw = 1'b0; addr = 9'h000; size = 2'b11; signedLoad = 1'b0;
        @(negedge Clk);
        req3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checkVal("mw3_latency", 32'(n), 32'd3);
        checkVal("mw3_rdata",   rdata3, 32'hCAFE0123);
        checkVal("mw3_err",     32'(err3), 32'd0);
        checkVal("mw3_act",     32'(act3), 32'd0);
        @(negedge Clk);

        for (int it = 0; it < 200; it++) begin
            rwR  = 1'($urandom);
            sgnR = 1'($urandom);
            szR  = 2'($urandom);
            aR   = 9'($urandom);
            if (szR == 2'b10 && $urandom_range(0, 9) < 8) szR = 2'b11;
            if ($urandom_range(0, 9) < 8) begin
                if (szR == 2'b11) aR[1:0] = 2'b00;
                if (szR == 2'b01) aR[0] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) latR = $urandom_range(0, 1) ? 0 : TIMEOUT + 1;
            else                           latR = $urandom_range(1, TIMEOUT);
            access(rwR, aR, szR, sgnR, $urandom, latR);
        end

        diffs = 0;
        for (int i = 0; i < 512; i++) if (ramMem[i] !== refMem[i]) diffs++;
        checkVal("mem_image", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
